cpu_clk_ctrl: RTL and testbench
===============================

# cpu_clk_ctrl

Clock-enable and step controller for the 8-bit teaching CPU on the board's single system clock. It replaces free-running divided clocks with single-cycle enable pulses:
- `cpu_en` advances the CPU at a switch-selected fast or slow rate, or once per debounced key press in single-step mode.
- `light_en` and the registered square wave `light_clk` drive the seven-segment display unit.

It sits between the board switches/keys and the CPU core plus display unit.

## Interface
Parameters:
- FAST_DIV, 50_000: cycles per cpu_en pulse in fast run mode (≥2)
- SLOW_DIV, 25_000_000: cycles per cpu_en pulse in slow run mode (≥FAST_DIV)
- LIGHT_DIV, 25_000: cycles per light_en pulse (≥2)
- DEB_CYCLES, 1_000_000: key debounce window in cycles (≥2)

Ports:
- clk  in  1  board system clock; sole clock
- clr  in  1  reset; synchronous, active-high
- SW_choose  in  1  async switch; 1 = fast, 0 = slow
- run_sw  in  1  async switch; 1 = free run, 0 = single step
- step_key  in  1  async raw pushbutton, active-low
- cpu_en  out  1  one-cycle CPU advance pulse
- light_en  out  1  one-cycle display refresh pulse
- light_clk  out  1  registered square wave, toggles on each light_en
- step_led  out  1  high while in single-step mode

## Operation
- **Synchronisers.** SW_choose, run_sw and step_key each pass through a 2-flop synchroniser. All logic uses the synchronised values (fast_s, run_s, key_s).
- **Run divider.**
  - Counter width is clog2(SLOW_DIV).
  - N = fast_s ? FAST_DIV : SLOW_DIV.
  - When run_s = 1, the counter increments. At count ≥ N−1 it wraps to 0 and registers run_tick = 1.
  - A fast/slow change mid-count therefore wraps at the next cycle if count already ≥ new N−1.
  - When run_s = 0, the counter is held at 0.
- **Mode change.** On any run_s transition, the counter clears to 0 and cpu_en stays 0 in that cycle.
- **Debounce FSM** (key_s, counter deb_cnt):
  - IDLE: key_s = 0 → PRESS_WAIT, deb_cnt = 0.
  - PRESS_WAIT: key_s = 1 → IDLE. Otherwise deb_cnt increments; at DEB_CYCLES−1 → PRESSED and step_pulse = 1 for one cycle.
  - PRESSED: key_s = 1 → RELEASE_WAIT, deb_cnt = 0.
  - RELEASE_WAIT: key_s = 0 → PRESSED, with no new pulse. Otherwise deb_cnt increments; at DEB_CYCLES−1 → IDLE.
- **Outputs.**
  - cpu_en (registered) = run_s ? run_tick : step_pulse. Step pulses in run mode are discarded.
  - Light divider: counts 0..LIGHT_DIV−1 regardless of mode and switches. On wrap, light_en = 1 for one cycle and light_clk toggles.
  - step_led = ~run_s.
- **Reset values** (clr at an edge):
  - counters = 0, FSM = IDLE
  - cpu_en = 0, light_en = 0, light_clk = 0
  - step/switch sync flops: SW_choose/run_sw sync = 0, key sync = 1; step_led = 1
  - A clr mid-press returns the FSM to IDLE; the held key must be released and re-pressed to step.

## Timing
- Synchroniser latency: 2 cycles.
- Run mode, inputs stable through reset: the first cpu_en is high after edge N+2, counting from the first edge with clr low. Thereafter exactly one pulse every N cycles.
- Step mode: the raw key held low is followed by cpu_en high DEB_CYCLES+3 cycles later (2 sync + DEB_CYCLES count + 1 output register).
- Exactly one pulse per press, regardless of hold time.
- cpu_en and light_en are never high for two consecutive cycles.
- light_clk period = 2·LIGHT_DIV cycles, duty 50%.
- No combinational path exists from any input to any output.

## Structure
- **Shared package cpu_clk_pkg:**
  - debounce state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT)
  - default divider constants
- **Sub-module key_debounce:** synchroniser plus FSM, producing step_pulse. It is instantiated once.
- The dividers and output register stay in the top of this block.

## Test plan
Parameters for all tests: FAST_DIV=4, SLOW_DIV=10, LIGHT_DIV=3, DEB_CYCLES=5.
- Reset, run_sw=1, SW_choose=1 → first cpu_en after edge 6, then every 4 cycles; step_led=0.
- Run mode, SW_choose 1→0 mid-count → pulse spacing becomes 10 cycles after 2-cycle sync. Switch back at count 7 → wrap next cycle, then 4-cycle spacing.
- run_sw=0, key low held 20 cycles → exactly one cpu_en, 8 cycles after the key falls. Bounce of 0,1,0 low pulses shorter than 5 cycles → no cpu_en.
- Release bounce (key 1 for 2 cycles, then 0) → no second pulse; a clean release plus re-press → second pulse.
- run_sw toggles 1→0→1 while key pressed → no cpu_en in toggle cycles; the run counter restarts from 0.
- Throughout: light_en every 3 cycles, light_clk period 6. clr asserted mid-PRESS_WAIT → all outputs reset, no pulse until the key is released and re-pressed.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared types and default divider constants for the CPU clock-enable controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int unsigned FAST_DIV_DEF   = 50_000;
  localparam int unsigned SLOW_DIV_DEF   = 25_000_000;
  localparam int unsigned LIGHT_DIV_DEF  = 25_000;
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// Step-key synchroniser and press/release debounce FSM; emits one step pulse per
// debounced press.
module key_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic step_pulse_c
);

  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  logic          key_meta;
  logic          key_s;
  logic [1:0]    sync_vld;
  logic          armed;
  deb_state_e    state;
  deb_state_e    state_nx;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_nx;

  // A key held through clr must be seen released before it can start a press.
  always_ff @(posedge clk) begin
    if (clr) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      key_meta <= key_raw;
      key_s    <= key_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & key_s);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      state   <= state_nx;
      deb_cnt <= deb_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    deb_cnt_nx   = deb_cnt;
    step_pulse_c = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !key_s) begin
          state_nx   = PRESS_WAIT;
          deb_cnt_nx = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_nx = IDLE;
        end else if (deb_cnt == DEB_MAX) begin
          state_nx     = PRESSED;
          step_pulse_c = 1'b1;
        end else begin
          deb_cnt_nx = deb_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_nx   = RELEASE_WAIT;
          deb_cnt_nx = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_nx = PRESSED;
        end else if (deb_cnt == DEB_MAX) begin
          state_nx = IDLE;
        end else begin
          deb_cnt_nx = deb_cnt + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU advance and display refresh enable generator: run/step mode selection,
// run-rate divider, display divider and registered outputs.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned FAST_DIV   = FAST_DIV_DEF,
  parameter int unsigned SLOW_DIV   = SLOW_DIV_DEF,
  parameter int unsigned LIGHT_DIV  = LIGHT_DIV_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic SW_choose,
  input  logic run_sw,
  input  logic step_key,
  output logic cpu_en,
  output logic light_en,
  output logic light_clk,
  output logic step_led
);

  localparam int unsigned CW = $clog2(SLOW_DIV);
  localparam int unsigned LW = $clog2(LIGHT_DIV);
  localparam logic [CW-1:0] FAST_MAX  = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0] SLOW_MAX  = CW'(SLOW_DIV - 1);
  localparam logic [LW-1:0] LIGHT_MAX = LW'(LIGHT_DIV - 1);

  logic          fast_meta;
  logic          fast_s;
  logic          run_meta;
  logic          run_s;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_max_c;
  logic          run_tick_c;
  logic          mode_chg_c;
  logic          step_pulse_c;
  logic [LW-1:0] light_cnt;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .clk          (clk),
    .clr          (clr),
    .key_raw      (step_key),
    .step_pulse_c (step_pulse_c)
  );

  // step_led tracks ~run_s exactly by sampling the same synchroniser stage.
  always_ff @(posedge clk) begin
    if (clr) begin
      fast_meta <= 1'b0;
      fast_s    <= 1'b0;
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_led  <= 1'b1;
    end else begin
      fast_meta <= SW_choose;
      fast_s    <= fast_meta;
      run_meta  <= run_sw;
      run_s     <= run_meta;
      step_led  <= ~run_meta;
    end
  end

  // Mode change is the edge on which run_s takes its new value.
  always_comb begin
    run_max_c  = fast_s ? FAST_MAX : SLOW_MAX;
    run_tick_c = run_s && (run_cnt >= run_max_c);
    mode_chg_c = run_meta != run_s;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      run_cnt <= '0;
      cpu_en  <= 1'b0;
    end else begin
      if (mode_chg_c || !run_s || run_tick_c) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
      cpu_en <= !mode_chg_c && (run_s ? run_tick_c : step_pulse_c);
    end
  end

  // Display divider is free-running, independent of mode and switches.
  always_ff @(posedge clk) begin
    if (clr) begin
      light_cnt <= '0;
      light_en  <= 1'b0;
      light_clk <= 1'b0;
    end else if (light_cnt == LIGHT_MAX) begin
      light_cnt <= '0;
      light_en  <= 1'b1;
      light_clk <= ~light_clk;
    end else begin
      light_cnt <= light_cnt + LW'(1);
      light_en  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with small dividers; cpu_en expectations are
// hand-placed pulse positions, display outputs follow a fixed 3-cycle cadence.
module tb_cpu_clk_ctrl;

  logic clk;
  logic clr;
  logic SW_choose;
  logic run_sw;
  logic step_key;
  logic cpu_en;
  logic light_en;
  logic light_clk;
  logic step_led;

  int checks;
  int fails;
  int lcyc;

  logic bounce_lvl [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   bounce_len [6] = '{4, 2, 2, 3, 4, 10};

  cpu_clk_ctrl #(
    .FAST_DIV   (4),
    .SLOW_DIV   (10),
    .LIGHT_DIV  (3),
    .DEB_CYCLES (5)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .SW_choose (SW_choose),
    .run_sw    (run_sw),
    .step_key  (step_key),
    .cpu_en    (cpu_en),
    .light_en  (light_en),
    .light_clk (light_clk),
    .step_led  (step_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock; display outputs checked against the 3-cycle cadence since clr release.
  task automatic tick();
    @(posedge clk);
    #1;
    lcyc++;
    chk(light_en, (lcyc % 3) == 0, "light_en");
    chk(light_clk, ((lcyc / 3) % 2) == 1, "light_clk");
  endtask

  // n cycles; cpu_en high at cycle 'first' (1-based) and every 'per' after (per=0: once).
  task automatic cyc_n(input int n, input int first, input int per, input string tag);
    logic exp;
    for (int i = 1; i <= n; i++) begin
      tick();
      exp = (first > 0) && (i >= first) &&
            ((per == 0) ? (i == first) : (((i - first) % per) == 0));
      chk(cpu_en, exp, tag);
    end
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk(cpu_en, 1'b0, "rst_cpu_en");
    chk(light_en, 1'b0, "rst_light_en");
    chk(light_clk, 1'b0, "rst_light_clk");
    chk(step_led, 1'b1, "rst_step_led");
    clr  = 1'b0;
    lcyc = 0;
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    lcyc      = 0;
    clr       = 1'b1;
    SW_choose = 1'b1;
    run_sw    = 1'b1;
    step_key  = 1'b1;

    do_reset(2);
    cyc_n(13, 6, 4, "fast_first");
    chk(step_led, 1'b0, "step_led_run");

    SW_choose = 1'b0;
    cyc_n(16, 1, 10, "to_slow");
    SW_choose = 1'b1;
    cyc_n(11, 3, 4, "back_to_fast");

    run_sw = 1'b0;
    cyc_n(6, 0, 0, "enter_step");
    chk(step_led, 1'b1, "step_led_step");

    step_key = 1'b0;
    cyc_n(20, 8, 0, "step_press");
    step_key = 1'b1;
    cyc_n(2, 0, 0, "rel_bounce_hi");
    step_key = 1'b0;
    cyc_n(8, 0, 0, "rel_bounce_lo");
    step_key = 1'b1;
    cyc_n(10, 0, 0, "clean_release");
    step_key = 1'b0;
    cyc_n(10, 8, 0, "repress");
    step_key = 1'b1;
    cyc_n(10, 0, 0, "release2");

    for (int k = 0; k < 6; k++) begin
      step_key = bounce_lvl[k];
      cyc_n(bounce_len[k], 0, 0, "press_bounce");
    end

    // Key pressed while entering run mode: its step pulse must be discarded.
    run_sw   = 1'b1;
    step_key = 1'b0;
    cyc_n(12, 6, 4, "run_key_held");
    run_sw = 1'b0;
    cyc_n(4, 0, 0, "toggle_off");
    run_sw = 1'b1;
    cyc_n(10, 6, 4, "toggle_on");

    run_sw   = 1'b0;
    step_key = 1'b1;
    cyc_n(14, 0, 0, "pre_clr_release");
    step_key = 1'b0;
    cyc_n(5, 0, 0, "press_wait");

    do_reset(2);
    cyc_n(20, 0, 0, "post_clr_held");
    step_key = 1'b1;
    cyc_n(6, 0, 0, "post_clr_release");
    step_key = 1'b0;
    cyc_n(10, 8, 0, "post_clr_press");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
